// File: rtl/mem_stage_if.sv
// Bus bundle between the E stage, the MEM/WB forward source and the M stage.
// Names match the pipeline's stage-suffixed signal naming.
interface mem_stage_if;
    logic [31:0] PCE;
    logic [31:0] ALUOutE;
    logic [31:0] RtDataE;
    logic [4:0]  RtAE;
    logic [4:0]  A3E;
    logic [3:0]  MemOpE;
    logic [1:0]  WDSelE;
    logic [4:0]  A3W;
    logic [31:0] WDW;
    logic [4:0]  A3M;
    logic [31:0] WDM;
    logic [31:0] PCM;
    logic        AddrErrM;
    logic [3:0]  BEM;

    modport master (
        output PCE, ALUOutE, RtDataE, RtAE, A3E, MemOpE, WDSelE, A3W, WDW,
        input  A3M, WDM, PCM, AddrErrM, BEM
    );

    modport slave (
        input  PCE, ALUOutE, RtDataE, RtAE, A3E, MemOpE, WDSelE, A3W, WDW,
        output A3M, WDM, PCM, AddrErrM, BEM
    );
endinterface

// File: rtl/mem_stage.sv
// MIPS M stage: EX/MEM register, byte-lane data memory, store lane generation,
// load extension and write-back data select.
module mem_stage #(
    parameter int DM_ADDR_W = 10
) (
    input logic        Clk,
    input logic        Reset,
    mem_stage_if.slave io
);
    localparam int DM_WORDS = 2 ** DM_ADDR_W;

    localparam logic [3:0] MOP_LW  = 4'd1;
    localparam logic [3:0] MOP_LH  = 4'd2;
    localparam logic [3:0] MOP_LHU = 4'd3;
    localparam logic [3:0] MOP_LB  = 4'd4;
    localparam logic [3:0] MOP_LBU = 4'd5;
    localparam logic [3:0] MOP_SW  = 4'd6;
    localparam logic [3:0] MOP_SH  = 4'd7;
    localparam logic [3:0] MOP_SB  = 4'd8;

    logic [31:0] pc_d, pc_q, alu_out_d, alu_out_q, rt_data_d, rt_data_q;
    logic [4:0]  rt_a_d, rt_a_q, a3_d, a3_q;
    logic [3:0]  mem_op_d, mem_op_q;
    logic [1:0]  wd_sel_d, wd_sel_q;

    logic [31:0] dm_q [DM_WORDS];

    logic [DM_ADDR_W-1:0] idx_s;
    logic [1:0]  off_s;
    logic [31:0] st_data_s, wr_data_s, rd_word_s, ld_data_s, wd_s;
    logic        misalign_s;
    logic [3:0]  be_s;

    // Next-state of the EX/MEM register; Reset forces MemOp none / WDSel ALU.
    always_comb begin
        pc_d      = 32'd0;
        alu_out_d = 32'd0;
        rt_data_d = 32'd0;
        rt_a_d    = 5'd0;
        a3_d      = 5'd0;
        mem_op_d  = 4'd0;
        wd_sel_d  = 2'd0;
        if (!Reset) begin
            pc_d      = io.PCE;
            alu_out_d = io.ALUOutE;
            rt_data_d = io.RtDataE;
            rt_a_d    = io.RtAE;
            a3_d      = io.A3E;
            mem_op_d  = io.MemOpE;
            wd_sel_d  = io.WDSelE;
        end else begin
            pc_d      = 32'd0;
        end
    end

    // EX/MEM pipeline register, no stall or flush.
    always_ff @(posedge Clk) begin
        pc_q      <= pc_d;
        alu_out_q <= alu_out_d;
        rt_data_q <= rt_data_d;
        rt_a_q    <= rt_a_d;
        a3_q      <= a3_d;
        mem_op_q  <= mem_op_d;
        wd_sel_q  <= wd_sel_d;
    end

    // Address split, store-data forward from MEM/WB, lane enables and replication.
    always_comb begin
        idx_s      = alu_out_q[DM_ADDR_W+1:2];
        off_s      = alu_out_q[1:0];
        st_data_s  = ((rt_a_q != 5'd0) && (rt_a_q == io.A3W)) ? io.WDW : rt_data_q;
        misalign_s = 1'b0;
        be_s       = 4'b0000;
        wr_data_s  = st_data_s;
        case (mem_op_q)
            MOP_LW, MOP_SW:          misalign_s = (off_s != 2'd0);
            MOP_LH, MOP_LHU, MOP_SH: misalign_s = off_s[0];
            default:                 misalign_s = 1'b0;
        endcase
        case (mem_op_q)
            MOP_SW: be_s = 4'b1111;
            MOP_SH: begin
                be_s      = off_s[1] ? 4'b1100 : 4'b0011;
                wr_data_s = {2{st_data_s[15:0]}};
            end
            MOP_SB: begin
                be_s      = 4'b0001 << off_s;
                wr_data_s = {4{st_data_s[7:0]}};
            end
            default: be_s = 4'b0000;
        endcase
        if (misalign_s) begin
            be_s = 4'b0000;
        end else begin
            be_s = be_s;
        end
    end

    // Data memory: cleared by Reset, which also blocks a store in the same cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < DM_WORDS; i++) begin
                dm_q[i] <= 32'd0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (be_s[b]) begin
                    dm_q[idx_s][8*b +: 8] <= wr_data_s[8*b +: 8];
                end
            end
        end
    end

    // Asynchronous load with extension, then write-back select.
    always_comb begin
        rd_word_s = dm_q[idx_s];
        ld_data_s = 32'd0;
        case (mem_op_q)
            MOP_LW:  ld_data_s = rd_word_s;
            MOP_LH:  ld_data_s = off_s[1] ? {{16{rd_word_s[31]}}, rd_word_s[31:16]}
                                          : {{16{rd_word_s[15]}}, rd_word_s[15:0]};
            MOP_LHU: ld_data_s = off_s[1] ? {16'd0, rd_word_s[31:16]}
                                          : {16'd0, rd_word_s[15:0]};
            MOP_LB:  ld_data_s = {{24{rd_word_s[8*off_s+7]}}, rd_word_s[8*off_s +: 8]};
            MOP_LBU: ld_data_s = {24'd0, rd_word_s[8*off_s +: 8]};
            default: ld_data_s = 32'd0;
        endcase
        if (misalign_s) begin
            ld_data_s = 32'd0;
        end else begin
            ld_data_s = ld_data_s;
        end
        case (wd_sel_q)
            2'd0:    wd_s = alu_out_q;
            2'd1:    wd_s = ld_data_s;
            2'd2:    wd_s = pc_q + 32'd8;
            default: wd_s = 32'd0;
        endcase
    end

    assign io.A3M      = a3_q;
    assign io.PCM      = pc_q;
    assign io.WDM      = wd_s;
    assign io.AddrErrM = misalign_s;
    assign io.BEM      = be_s;
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: each step issues one E-stage op and checks the
// M-stage outputs one cycle later against hand-computed values.
module tb_mem_stage;
    logic Clk = 1'b0;
    logic Reset;
    int   errors = 0;
    int   checks = 0;

    localparam logic [3:0] LW = 4'd1, LH = 4'd2, LHU = 4'd3, LB = 4'd4, LBU = 4'd5;
    localparam logic [3:0] SW = 4'd6, SH = 4'd7, SB = 4'd8;

    mem_stage_if bus ();

    mem_stage #(.DM_ADDR_W(10)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .io    (bus.slave)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rt,
                         input logic [4:0] rta, input logic [4:0] a3,
                         input logic [3:0] op, input logic [1:0] sel);
        bus.PCE     = pc;
        bus.ALUOutE = alu;
        bus.RtDataE = rt;
        bus.RtAE    = rta;
        bus.A3E     = a3;
        bus.MemOpE  = op;
        bus.WDSelE  = sel;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset   = 1'b1;
        bus.A3W = 5'd0;
        bus.WDW = 32'd0;
        issue(32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 4'd0, 2'd0);
        issue(32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 4'd0, 2'd0);
        Reset = 1'b0;

        // 1: preload, then reset with a store in M; everything reads back 0
        issue(32'h100, 32'h0, 32'hCAFE_F00D, 5'd3, 5'd0, SW, 2'd0);
        check("pre_sw_be", {28'd0, bus.BEM}, 32'h0000_000F);
        issue(32'h104, 32'h0, 32'd0, 5'd0, 5'd5, LW, 2'd1);
        check("pre_lw", bus.WDM, 32'hCAFE_F00D);
        check("pre_a3m", {27'd0, bus.A3M}, 32'd5);
        check("pre_pcm", bus.PCM, 32'h104);
        issue(32'h108, 32'h10, 32'h0000_55AA, 5'd3, 5'd0, SW, 2'd0);
        Reset = 1'b1;
        issue(32'h10C, 32'h44, 32'h77, 5'd3, 5'd9, SW, 2'd2);
        check("rst_a3m", {27'd0, bus.A3M}, 32'd0);
        check("rst_pcm", bus.PCM, 32'd0);
        check("rst_wdm", bus.WDM, 32'd0);
        check("rst_bem", {28'd0, bus.BEM}, 32'd0);
        check("rst_aerr", {31'd0, bus.AddrErrM}, 32'd0);
        Reset = 1'b0;
        issue(32'h110, 32'h0, 32'd0, 5'd0, 5'd6, LW, 2'd1);
        check("rst_lw0", bus.WDM, 32'd0);
        issue(32'h114, 32'h10, 32'd0, 5'd0, 5'd6, LW, 2'd1);
        check("rst_lw10", bus.WDM, 32'd0);

        // 2: store word then every load flavour of it
        issue(32'h200, 32'h10, 32'h8000_00FF, 5'd3, 5'd0, SW, 2'd0);
        check("sw_wdm_alu", bus.WDM, 32'h10);
        issue(32'h204, 32'h10, 32'd0, 5'd0, 5'd2, LB, 2'd1);
        check("lb", bus.WDM, 32'hFFFF_FFFF);
        issue(32'h208, 32'h10, 32'd0, 5'd0, 5'd2, LBU, 2'd1);
        check("lbu", bus.WDM, 32'h0000_00FF);
        issue(32'h20C, 32'h10, 32'd0, 5'd0, 5'd2, LH, 2'd1);
        check("lh", bus.WDM, 32'h0000_00FF);
        issue(32'h210, 32'h10, 32'd0, 5'd0, 5'd2, LHU, 2'd1);
        check("lhu", bus.WDM, 32'h0000_00FF);
        issue(32'h214, 32'h10, 32'd0, 5'd0, 5'd2, LW, 2'd1);
        check("lw", bus.WDM, 32'h8000_00FF);

        // 3: byte and half merges into an existing word
        issue(32'h300, 32'h10, 32'h1122_3344, 5'd3, 5'd0, SW, 2'd0);
        issue(32'h304, 32'h13, 32'h0000_00AB, 5'd3, 5'd0, SB, 2'd0);
        check("sb_be", {28'd0, bus.BEM}, 32'h0000_0008);
        issue(32'h308, 32'h10, 32'd0, 5'd0, 5'd2, LW, 2'd1);
        check("sb_word", bus.WDM, 32'hAB22_3344);
        issue(32'h30C, 32'h12, 32'h0000_BEEF, 5'd3, 5'd0, SH, 2'd0);
        check("sh_be", {28'd0, bus.BEM}, 32'h0000_000C);
        issue(32'h310, 32'h12, 32'd0, 5'd0, 5'd2, LH, 2'd1);
        check("sh_lh_hi", bus.WDM, 32'hFFFF_BEEF);
        issue(32'h314, 32'h10, 32'd0, 5'd0, 5'd2, LHU, 2'd1);
        check("lhu_lo", bus.WDM, 32'h0000_3344);
        issue(32'h318, 32'h10, 32'd0, 5'd0, 5'd2, LW, 2'd1);
        check("sh_word", bus.WDM, 32'hBEEF_3344);

        // 4: misaligned store suppressed, misaligned load returns 0
        issue(32'h400, 32'h4, 32'h1357_2468, 5'd3, 5'd0, SW, 2'd0);
        issue(32'h404, 32'h6, 32'h0000_0099, 5'd3, 5'd0, SW, 2'd0);
        check("mis_sw_aerr", {31'd0, bus.AddrErrM}, 32'd1);
        check("mis_sw_be", {28'd0, bus.BEM}, 32'd0);
        issue(32'h408, 32'h4, 32'd0, 5'd0, 5'd2, LW, 2'd1);
        check("mis_sw_keep", bus.WDM, 32'h1357_2468);
        check("al_lw_aerr", {31'd0, bus.AddrErrM}, 32'd0);
        issue(32'h40C, 32'h5, 32'd0, 5'd0, 5'd2, LH, 2'd1);
        check("mis_lh_aerr", {31'd0, bus.AddrErrM}, 32'd1);
        check("mis_lh_wdm", bus.WDM, 32'd0);

        // 5: store data forwarded from MEM/WB, and not forwarded for $0
        bus.A3W = 5'd8;
        bus.WDW = 32'hDEAD_BEEF;
        issue(32'h500, 32'h20, 32'h1, 5'd8, 5'd0, SW, 2'd0);
        issue(32'h504, 32'h20, 32'd0, 5'd0, 5'd2, LW, 2'd1);
        check("fwd_w", bus.WDM, 32'hDEAD_BEEF);
        bus.A3W = 5'd0;
        bus.WDW = 32'hFFFF_FFFF;
        issue(32'h508, 32'h20, 32'h1, 5'd0, 5'd0, SW, 2'd0);
        issue(32'h50C, 32'h20, 32'd0, 5'd0, 5'd2, LW, 2'd1);
        check("fwd_r0", bus.WDM, 32'h0000_0001);

        // 6: PC+8 wrap, WDSel 3, address aliasing past the DM size
        issue(32'hFFFF_FFFC, 32'h1234, 32'd0, 5'd0, 5'd31, 4'd0, 2'd2);
        check("pc8_wrap", bus.WDM, 32'h0000_0004);
        check("pc8_pcm", bus.PCM, 32'hFFFF_FFFC);
        check("pc8_a3m", {27'd0, bus.A3M}, 32'd31);
        issue(32'h600, 32'h1234, 32'd0, 5'd0, 5'd1, 4'd0, 2'd3);
        check("wdsel3", bus.WDM, 32'd0);
        issue(32'h604, 32'h1000, 32'hA5A5_A5A5, 5'd3, 5'd0, SW, 2'd0);
        issue(32'h608, 32'h0, 32'd0, 5'd0, 5'd2, LW, 2'd1);
        check("alias_0", bus.WDM, 32'hA5A5_A5A5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
